// File: rtl/mul_iter_pkg.sv
// Shared types and sizing helpers for the iterative unsigned multiplier.
package mul_iter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int unsigned prod_width(input int unsigned width,
                                               input int unsigned full_product);
        return (full_product != 0) ? 2 * width : width;
    endfunction

    function automatic int unsigned num_steps(input int unsigned width,
                                              input int unsigned digit);
        return width / digit;
    endfunction

    // Counter must reach N itself, hence clog2(N+1).
    function automatic int unsigned cnt_width(input int unsigned width,
                                              input int unsigned digit);
        return $clog2(num_steps(width, digit) + 1);
    endfunction

endpackage

// File: rtl/mul_digit_pp.sv
// WIDTH x DIGIT partial-product generator feeding the iterative accumulator.
module mul_digit_pp
    import mul_iter_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 2
) (
    input  logic [WIDTH-1:0]       a_i,
    input  logic [DIGIT-1:0]       d_i,
    output logic [WIDTH+DIGIT-1:0] pp_o
);

    localparam int unsigned PPW = WIDTH + DIGIT;

    generate
        if (DIGIT == 2) begin : g_nbit
            multiplier_nbit #(
                .AW (WIDTH),
                .BW (DIGIT)
            ) u_mult (
                .a_i (a_i),
                .b_i (d_i),
                .p_o (pp_o)
            );
        end else begin : g_direct
            assign pp_o = PPW'(a_i) * PPW'(d_i);
        end
    endgenerate

endmodule

// File: rtl/multiplier_nbit.sv
// Generic combinational shift-add multiplier, AW x BW -> AW+BW bits.
module multiplier_nbit #(
    parameter int unsigned AW = 4,
    parameter int unsigned BW = 4
) (
    input  logic [AW-1:0]    a_i,
    input  logic [BW-1:0]    b_i,
    output logic [AW+BW-1:0] p_o
);

    localparam int unsigned PW = AW + BW;

    always_comb begin
        p_o = '0;
        for (int i = 0; i < int'(BW); i++) begin
            if (b_i[i]) begin
                p_o = p_o + (PW'(a_i) << i);
            end
        end
    end

endmodule

// File: rtl/mul_uint_iter.sv
// Iterative unsigned multiplier: one DIGIT-bit slice of B per clock,
// valid/ready on both sides, optional early exit on an exhausted multiplier.
module mul_uint_iter
    import mul_iter_pkg::*;
#(
    parameter int unsigned WIDTH        = 8,
    parameter int unsigned DIGIT        = 2,
    parameter int unsigned FULL_PRODUCT = 0,
    parameter int unsigned EARLY_EXIT   = 1
) (
    input  logic                                         clk,
    input  logic                                         rst,
    input  logic                                         in_valid,
    output logic                                         in_ready,
    input  logic [WIDTH-1:0]                             A,
    input  logic [WIDTH-1:0]                             B,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [prod_width(WIDTH, FULL_PRODUCT)-1:0]   P,
    output logic                                         busy
);

    localparam int unsigned N   = num_steps(WIDTH, DIGIT);
    localparam int unsigned CW  = cnt_width(WIDTH, DIGIT);
    localparam int unsigned AW  = prod_width(WIDTH, FULL_PRODUCT);
    localparam int unsigned PPW = WIDTH + DIGIT;
    localparam int unsigned SW  = (AW > PPW) ? AW : PPW;

    generate
        if ((WIDTH < 2) || (WIDTH % DIGIT != 0) ||
            !((DIGIT == 1) || (DIGIT == 2) || (DIGIT == 4))) begin : g_bad_params
            $error("mul_uint_iter: illegal WIDTH/DIGIT combination");
        end
    endgenerate

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] bsh_q, bsh_d;
    logic [AW-1:0]    acc_q, acc_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic             busy_q, busy_d;

    logic [PPW-1:0]   pp;
    logic [SW-1:0]    pp_sh;

    mul_digit_pp #(
        .WIDTH (WIDTH),
        .DIGIT (DIGIT)
    ) u_pp (
        .a_i  (a_q),
        .d_i  (bsh_q[DIGIT-1:0]),
        .pp_o (pp)
    );

    // Shift is done at the wider of acc/pp width; truncation to AW happens on the sum.
    assign pp_sh = SW'(pp) << (32'(DIGIT) * 32'(cnt_q));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            a_q         <= '0;
            bsh_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            bsh_q       <= bsh_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        a_d         = a_q;
        bsh_d       = bsh_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        unique case (state_q)
            IDLE: begin
                if (in_valid && in_ready_q) begin
                    a_d        = A;
                    bsh_d      = B;
                    acc_d      = '0;
                    cnt_d      = '0;
                    state_d    = BUSY;
                    in_ready_d = 1'b0;
                    busy_d     = 1'b1;
                end
            end
            BUSY: begin
                acc_d = AW'(SW'(acc_q) + pp_sh);
                bsh_d = bsh_q >> DIGIT;
                cnt_d = cnt_q + CW'(1);
                // Leave after the last digit, or as soon as no multiplier bits remain.
                if ((cnt_q == CW'(N - 1)) || ((EARLY_EXIT != 0) && (bsh_d == '0))) begin
                    state_d     = DONE;
                    busy_d      = 1'b0;
                    out_valid_d = 1'b1;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                busy_d      = 1'b0;
            end
        endcase
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign busy      = busy_q;
    assign P         = acc_q;

endmodule

// File: tb/tb_mul_uint_iter.sv
// Directed bench for mul_uint_iter across full/truncated, fixed/early-exit
// and a 4-bit exhaustive configuration.
module tb_mul_uint_iter;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [7:0]  a8 = '0, b8 = '0;
    logic [3:0]  a4 = '0, b4 = '0;

    logic        iv_f = 0, or_f = 0, ir_f, ov_f, busy_f;
    logic [15:0] p_f;
    logic        iv_t = 0, or_t = 0, ir_t, ov_t, busy_t;
    logic [7:0]  p_t;
    logic        iv_e = 0, or_e = 0, ir_e, ov_e, busy_e;
    logic [15:0] p_e;
    logic        iv_4 = 0, or_4 = 0, ir_4, ov_4, busy_4;
    logic [3:0]  p_4;

    int errors = 0;
    int checks = 0;

    mul_uint_iter #(.WIDTH(8), .DIGIT(2), .FULL_PRODUCT(1), .EARLY_EXIT(0)) u_full (
        .clk(clk), .rst(rst), .in_valid(iv_f), .in_ready(ir_f), .A(a8), .B(b8),
        .out_valid(ov_f), .out_ready(or_f), .P(p_f), .busy(busy_f));

    mul_uint_iter #(.WIDTH(8), .DIGIT(2), .FULL_PRODUCT(0), .EARLY_EXIT(0)) u_trunc (
        .clk(clk), .rst(rst), .in_valid(iv_t), .in_ready(ir_t), .A(a8), .B(b8),
        .out_valid(ov_t), .out_ready(or_t), .P(p_t), .busy(busy_t));

    mul_uint_iter #(.WIDTH(8), .DIGIT(2), .FULL_PRODUCT(1), .EARLY_EXIT(1)) u_ee (
        .clk(clk), .rst(rst), .in_valid(iv_e), .in_ready(ir_e), .A(a8), .B(b8),
        .out_valid(ov_e), .out_ready(or_e), .P(p_e), .busy(busy_e));

    mul_uint_iter #(.WIDTH(4), .DIGIT(2), .FULL_PRODUCT(0), .EARLY_EXIT(1)) u_w4 (
        .clk(clk), .rst(rst), .in_valid(iv_4), .in_ready(ir_4), .A(a4), .B(b4),
        .out_valid(ov_4), .out_ready(or_4), .P(p_4), .busy(busy_4));

    // sel: 0 = u_full, 1 = u_trunc, 2 = u_ee
    task automatic set_iv(input int sel, input logic v);
        case (sel)
            0: iv_f = v;
            1: iv_t = v;
            default: iv_e = v;
        endcase
    endtask

    task automatic set_or(input int sel, input logic v);
        case (sel)
            0: or_f = v;
            1: or_t = v;
            default: or_e = v;
        endcase
    endtask

    function automatic logic ov8(input int sel);
        case (sel)
            0: return ov_f;
            1: return ov_t;
            default: return ov_e;
        endcase
    endfunction

    function automatic logic [15:0] p8(input int sel);
        case (sel)
            0: return p_f;
            1: return 16'(p_t);
            default: return p_e;
        endcase
    endfunction

    // One complete transaction; cyc = negedges from accept until out_valid seen.
    task automatic run8(input int sel, input logic [7:0] a, input logic [7:0] b,
                        output logic [15:0] p, output int cyc);
        @(negedge clk);
        a8 = a; b8 = b; set_iv(sel, 1'b1);
        @(negedge clk);
        set_iv(sel, 1'b0);
        cyc = 0;
        while (!ov8(sel) && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        p = p8(sel);
        set_or(sel, 1'b1);
        @(negedge clk);
        set_or(sel, 1'b0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (ir_f !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", ir_f); end
        checks++; if (ov_f !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", ov_f); end
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_f); end
        checks++; if (p_f !== 16'h0) begin errors++; $display("FAIL reset_p got=%h exp=0000", p_f); end
        checks++; if (ir_4 !== 1'b1) begin errors++; $display("FAIL reset_in_ready_w4 got=%b exp=1", ir_4); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_latency();
        int cyc, nbusy;
        @(negedge clk);
        a8 = 8'd13; b8 = 8'd11; iv_f = 1'b1;
        @(negedge clk);
        iv_f = 1'b0;
        cyc = 0; nbusy = 0;
        while (!ov_f && cyc < 40) begin
            if (busy_f) nbusy++;
            @(negedge clk);
            cyc++;
        end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL latency_13x11 got=%0d exp=4", cyc); end
        checks++; if (nbusy !== 4) begin errors++; $display("FAIL busy_cycles got=%0d exp=4", nbusy); end
        checks++; if (p_f !== 16'h008F) begin errors++; $display("FAIL p_13x11 got=%h exp=008f", p_f); end
        checks++; if (busy_f !== 1'b0) begin errors++; $display("FAIL busy_in_done got=%b exp=0", busy_f); end
        or_f = 1'b1;
        @(negedge clk);
        or_f = 1'b0;
        checks++; if (ov_f !== 1'b0 || ir_f !== 1'b1) begin
            errors++; $display("FAIL return_idle ov=%b ir=%b exp ov=0 ir=1", ov_f, ir_f);
        end
    endtask

    task automatic test_overflow();
        logic [15:0] p;
        int cyc;
        run8(1, 8'd255, 8'd255, p, cyc);
        checks++; if (p !== 16'h0001) begin errors++; $display("FAIL trunc_255x255 got=%h exp=0001", p); end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL trunc_latency got=%0d exp=4", cyc); end
        run8(0, 8'd255, 8'd255, p, cyc);
        checks++; if (p !== 16'hFE01) begin errors++; $display("FAIL full_255x255 got=%h exp=fe01", p); end
    endtask

    task automatic test_early_exit();
        logic [15:0] p;
        int cyc;
        run8(2, 8'd200, 8'd3, p, cyc);
        checks++; if (p !== 16'd600) begin errors++; $display("FAIL ee_200x3 got=%0d exp=600", p); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL ee_200x3_lat got=%0d exp=1", cyc); end
        run8(2, 8'd77, 8'd0, p, cyc);
        checks++; if (p !== 16'd0) begin errors++; $display("FAIL ee_b0 got=%0d exp=0", p); end
        checks++; if (cyc !== 1) begin errors++; $display("FAIL ee_b0_lat got=%0d exp=1", cyc); end
        run8(2, 8'd5, 8'h80, p, cyc);
        checks++; if (p !== 16'd640) begin errors++; $display("FAIL ee_5x80 got=%0d exp=640", p); end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL ee_5x80_lat got=%0d exp=4", cyc); end
        run8(2, 8'd3, 8'h10, p, cyc);
        checks++; if (p !== 16'd48) begin errors++; $display("FAIL ee_3x16 got=%0d exp=48", p); end
        checks++; if (cyc !== 3) begin errors++; $display("FAIL ee_3x16_lat got=%0d exp=3", cyc); end
    endtask

    task automatic test_backpressure();
        int cyc;
        @(negedge clk);
        a8 = 8'd6; b8 = 8'd7; iv_f = 1'b1;
        @(negedge clk);
        iv_f = 1'b0;
        cyc = 0;
        while (!ov_f && cyc < 40) begin @(negedge clk); cyc++; end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin a8 = 8'd99; b8 = 8'd99; iv_f = 1'b1; end
            if (i == 2) iv_f = 1'b0;
            checks++; if (ov_f !== 1'b1 || p_f !== 16'd42 || ir_f !== 1'b0) begin
                errors++; $display("FAIL stall_%0d ov=%b p=%0d ir=%b exp ov=1 p=42 ir=0", i, ov_f, p_f, ir_f);
            end
            @(negedge clk);
        end
        or_f = 1'b1;
        @(negedge clk);
        or_f = 1'b0;
        checks++; if (ov_f !== 1'b0 || ir_f !== 1'b1) begin
            errors++; $display("FAIL bp_release ov=%b ir=%b exp ov=0 ir=1", ov_f, ir_f);
        end
        @(negedge clk);
        checks++; if (busy_f !== 1'b0 || ir_f !== 1'b1) begin
            errors++; $display("FAIL bp_no_accept busy=%b ir=%b exp busy=0 ir=1", busy_f, ir_f);
        end
    endtask

    task automatic test_reset_mid_busy();
        logic [15:0] p;
        int cyc;
        @(negedge clk);
        a8 = 8'd50; b8 = 8'd200; iv_f = 1'b1;
        @(negedge clk);
        iv_f = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (ov_f !== 1'b0 || ir_f !== 1'b1 || busy_f !== 1'b0 || p_f !== 16'h0) begin
            errors++; $display("FAIL mid_busy_reset ov=%b ir=%b busy=%b p=%h exp 0/1/0/0000", ov_f, ir_f, busy_f, p_f);
        end
        @(negedge clk);
        rst = 1'b0;
        run8(0, 8'd7, 8'd9, p, cyc);
        checks++; if (p !== 16'd63) begin errors++; $display("FAIL after_reset_7x9 got=%0d exp=63", p); end
        checks++; if (cyc !== 4) begin errors++; $display("FAIL after_reset_lat got=%0d exp=4", cyc); end
    endtask

    task automatic test_back_to_back();
        int cyc;
        logic hs;
        logic [3:0] exp_p;
        for (int a = 0; a < 16; a++) begin
            for (int b = 0; b < 16; b++) begin
                a4 = 4'(a); b4 = 4'(b); iv_4 = 1'b1;
                @(negedge clk);
                iv_4 = 1'b0;
                cyc = 0;
                while (!ov_4 && cyc < 40) begin
                    or_4 = 1'($urandom_range(0, 1));
                    @(negedge clk);
                    cyc++;
                end
                exp_p = 4'((a * b) & 15);
                checks++; if (ov_4 !== 1'b1 || p_4 !== exp_p) begin
                    errors++; $display("FAIL w4_%0dx%0d ov=%b got=%0d exp=%0d", a, b, ov_4, p_4, exp_p);
                end
                hs = 1'b0;
                cyc = 0;
                while (!hs && cyc < 40) begin
                    or_4 = 1'($urandom_range(0, 1));
                    hs = or_4;
                    @(negedge clk);
                    cyc++;
                end
                or_4 = 1'b0;
            end
        end
        checks++; if (ir_4 !== 1'b1 || ov_4 !== 1'b0) begin
            errors++; $display("FAIL w4_final_idle ir=%b ov=%b exp ir=1 ov=0", ir_4, ov_4);
        end
    endtask

    initial begin
        test_reset();
        test_latency();
        test_overflow();
        test_early_exit();
        test_backpressure();
        test_reset_mid_busy();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
